// File: rtl/snake_step_sequencer.sv
// ----------------------------------------------------------------------------
// snake_step_sequencer
//   Owns the snake body and advances it one game step per tick. The tick is
//   derived by counting frame_start pulses. Each step latches the steering
//   command into the heading, computes the new head, scans the body for a
//   self-hit, checks the target, then shifts (and optionally grows) the body.
//
// Ports
//   clock, reset             system clock, async active-high reset
//   frame_start              one-cycle pulse per video frame
//   move_valid/move/move_ready  steering command handshake (ready only in IDLE)
//   target_x/y, target_valid current target position
//   seg_rd_idx -> seg_rd_x/y combinational segment read, 0 beyond length
//   head_x/y, length, heading   body state
//   target_eaten, step_done  one-cycle pulses
//   busy, game_over          status (game_over sticky until reset)
// ----------------------------------------------------------------------------

// One body segment register. Segment 0 loads the new head; segment k loads
// segment k-1 whenever the body shifts.
module snake_seg_reg #(
  parameter int                 COORD_W = 10,
  parameter logic [COORD_W-1:0] RST_X   = '0,
  parameter logic [COORD_W-1:0] RST_Y   = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               shift_en,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic [COORD_W-1:0] seg_x,
  output logic [COORD_W-1:0] seg_y
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_x <= RST_X;
      seg_y <= RST_Y;
    end else if (shift_en) begin
      seg_x <= load_x;
      seg_y <= load_y;
    end
  end

endmodule

module snake_step_sequencer #(
  parameter int MAX_LEN  = 25,
  parameter int COORD_W  = 10,
  parameter int STEP     = 10,
  parameter int TICK_DIV = 6,
  parameter int X_MIN    = 300,
  parameter int X_MAX    = 990,
  parameter int Y_MIN    = 50,
  parameter int Y_MAX    = 590,
  parameter int INIT_X   = 500,
  parameter int INIT_Y   = 400
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               move_valid,
  input  logic [1:0]         move,
  output logic               move_ready,
  input  logic [COORD_W-1:0] target_x,
  input  logic [COORD_W-1:0] target_y,
  input  logic               target_valid,
  input  logic [4:0]         seg_rd_idx,
  output logic [COORD_W-1:0] seg_rd_x,
  output logic [COORD_W-1:0] seg_rd_y,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [4:0]         length,
  output logic [1:0]         heading,
  output logic               target_eaten,
  output logic               step_done,
  output logic               busy,
  output logic               game_over
);

  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] H_E = 2'b00;
  localparam logic [1:0] H_W = 2'b01;
  localparam logic [1:0] H_N = 2'b11;
  localparam logic [1:0] H_S = 2'b10;

  localparam logic [1:0] CMD_RIGHT = 2'b10;
  localparam logic [1:0] CMD_LEFT  = 2'b01;

  // Head arithmetic runs one bit wider so a step below 0 shows up in the MSB.
  localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0] XMIN_W = (COORD_W+1)'(X_MIN);
  localparam logic [COORD_W:0] XMAX_W = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] YMIN_W = (COORD_W+1)'(Y_MIN);
  localparam logic [COORD_W:0] YMAX_W = (COORD_W+1)'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CALC, S_SCAN, S_SHIFT, S_OVER
  } state_t;

  state_t                           state;
  logic [TCNT_W-1:0]                tick_cnt;
  logic                             tick_wrap;
  logic                             pending;
  logic [1:0]                       cmd;
  logic [COORD_W-1:0]               nh_x, nh_y;
  logic                             eat;
  logic [4:0]                       scan_n, scan_i;
  logic                             shift_en;
  logic [MAX_LEN-1:0][COORD_W-1:0]  seg_x, seg_y;

  logic [COORD_W:0]                 calc_x, calc_y;
  logic                             calc_oob, calc_eat;
  logic                             scan_hit;

  // --------------------------------------------------------------------------
  // Body storage: segment 0 takes the new head, the rest ripple down.
  // Segments past length keep shifting too; they are invisible on the read
  // port and become the retained tail when the body grows.
  // --------------------------------------------------------------------------
  assign shift_en = (state == S_SHIFT);

  for (genvar k = 0; k < MAX_LEN; k++) begin : g_seg
    localparam logic [COORD_W-1:0] RX = (k == 0) ? COORD_W'(INIT_X) :
                                        (k == 1) ? COORD_W'(INIT_X - STEP) : '0;
    localparam logic [COORD_W-1:0] RY = (k < 2) ? COORD_W'(INIT_Y) : '0;
    logic [COORD_W-1:0] src_x, src_y;

    if (k == 0) begin : g_head
      assign src_x = nh_x;
      assign src_y = nh_y;
    end else begin : g_body
      assign src_x = seg_x[k-1];
      assign src_y = seg_y[k-1];
    end

    snake_seg_reg #(
      .COORD_W (COORD_W),
      .RST_X   (RX),
      .RST_Y   (RY)
    ) u_seg (
      .clock    (clock),
      .reset    (reset),
      .shift_en (shift_en),
      .load_x   (src_x),
      .load_y   (src_y),
      .seg_x    (seg_x[k]),
      .seg_y    (seg_y[k])
    );
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  always_comb begin
    seg_rd_x = '0;
    seg_rd_y = '0;
    if (seg_rd_idx < length) begin
      seg_rd_x = seg_x[seg_rd_idx];
      seg_rd_y = seg_y[seg_rd_idx];
    end
  end

  // --------------------------------------------------------------------------
  // New head candidate from the current head and (already latched) heading.
  // y grows southward.
  // --------------------------------------------------------------------------
  always_comb begin
    calc_x = {1'b0, seg_x[0]};
    calc_y = {1'b0, seg_y[0]};
    case (heading)
      H_E:     calc_x = {1'b0, seg_x[0]} + STEP_W;
      H_W:     calc_x = {1'b0, seg_x[0]} - STEP_W;
      H_S:     calc_y = {1'b0, seg_y[0]} + STEP_W;
      default: calc_y = {1'b0, seg_y[0]} - STEP_W;
    endcase
    calc_oob = calc_x[COORD_W] || calc_y[COORD_W] ||
               (calc_x < XMIN_W) || (calc_x > XMAX_W) ||
               (calc_y < YMIN_W) || (calc_y > YMAX_W);
    calc_eat = target_valid &&
               (calc_x[COORD_W-1:0] == target_x) &&
               (calc_y[COORD_W-1:0] == target_y);
  end

  assign scan_hit  = (seg_x[scan_i] == nh_x) && (seg_y[scan_i] == nh_y);
  assign tick_wrap = (tick_cnt == TCNT_W'(TICK_DIV - 1));

  function automatic logic [1:0] turn(input logic [1:0] h, input logic [1:0] c);
    logic [1:0] r;
    r = h;
    if (c == CMD_RIGHT) begin
      case (h)
        H_E:     r = H_S;
        H_S:     r = H_W;
        H_W:     r = H_N;
        default: r = H_E;
      endcase
    end else if (c == CMD_LEFT) begin
      case (h)
        H_E:     r = H_N;
        H_N:     r = H_W;
        H_W:     r = H_S;
        default: r = H_E;
      endcase
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Tick divider, command latch and step FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      pending      <= 1'b0;
      cmd          <= 2'b00;
      heading      <= H_E;
      length       <= 5'd2;
      nh_x         <= '0;
      nh_y         <= '0;
      eat          <= 1'b0;
      scan_n       <= '0;
      scan_i       <= '0;
      move_ready   <= 1'b1;
      busy         <= 1'b0;
      game_over    <= 1'b0;
      target_eaten <= 1'b0;
      step_done    <= 1'b0;
    end else begin
      target_eaten <= 1'b0;
      step_done    <= 1'b0;

      // Frames are counted in every state, including while a step runs.
      if (frame_start)
        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;

      // Consuming the pending tick wins over a coincident wrap; a wrap while
      // pending is already set is simply absorbed.
      if (state == S_IDLE && pending)
        pending <= 1'b0;
      else if (frame_start && tick_wrap)
        pending <= 1'b1;

      if (move_valid && move_ready)
        cmd <= move;

      case (state)
        S_IDLE: begin
          if (pending) begin
            state      <= S_LATCH;
            move_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_LATCH: begin
          heading <= turn(heading, cmd);
          cmd     <= 2'b00;
          state   <= S_CALC;
        end
        S_CALC: begin
          nh_x   <= calc_x[COORD_W-1:0];
          nh_y   <= calc_y[COORD_W-1:0];
          eat    <= calc_eat;
          // The tail vacates its cell this step unless the body grows.
          scan_n <= calc_eat ? length : length - 5'd1;
          scan_i <= '0;
          if (calc_oob) begin
            state     <= S_OVER;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (scan_hit) begin
            state     <= S_OVER;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else if (scan_i == scan_n - 5'd1) begin
            state <= S_SHIFT;
          end else begin
            scan_i <= scan_i + 5'd1;
          end
        end
        S_SHIFT: begin
          if (eat) begin
            target_eaten <= 1'b1;
            if (length < 5'(MAX_LEN))
              length <= length + 5'd1;
          end
          state      <= S_IDLE;
          busy       <= 1'b0;
          move_ready <= 1'b1;
          step_done  <= 1'b1;
        end
        S_OVER: begin
          game_over <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_step_sequencer.sv
module tb_snake_step_sequencer;

  localparam int COORD_W = 10;
  localparam int BUDGET  = 40;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               frame_start = 1'b0;
  logic               move_valid = 1'b0;
  logic [1:0]         move = 2'b00;
  logic               move_ready;
  logic [COORD_W-1:0] target_x = '0;
  logic [COORD_W-1:0] target_y = '0;
  logic               target_valid = 1'b0;
  logic [4:0]         seg_rd_idx = '0;
  logic [COORD_W-1:0] seg_rd_x, seg_rd_y, head_x, head_y;
  logic [4:0]         length;
  logic [1:0]         heading;
  logic               target_eaten, step_done, busy, game_over;

  snake_step_sequencer #(.TICK_DIV(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .move_valid   (move_valid),
    .move         (move),
    .move_ready   (move_ready),
    .target_x     (target_x),
    .target_y     (target_y),
    .target_valid (target_valid),
    .seg_rd_idx   (seg_rd_idx),
    .seg_rd_x     (seg_rd_x),
    .seg_rd_y     (seg_rd_y),
    .head_x       (head_x),
    .head_y       (head_y),
    .length       (length),
    .heading      (heading),
    .target_eaten (target_eaten),
    .step_done    (step_done),
    .busy         (busy),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int lat, eaten, tot;
  logic [COORD_W-1:0] rx, ry;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input int idx, input int ex, input int ey);
    seg_rd_idx = 5'(idx);
    #1;
    chk({tag, ".x"}, 32'(seg_rd_x), ex);
    chk({tag, ".y"}, 32'(seg_rd_y), ey);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; frame_start = 1'b0; move_valid = 1'b0; target_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge clock); frame_start = 1'b1;
    @(negedge clock); frame_start = 1'b0;
  endtask

  task automatic send_move(input logic [1:0] m);
    @(negedge clock); move_valid = 1'b1; move = m;
    @(negedge clock); move_valid = 1'b0; move = 2'b00;
  endtask

  // Called just after the edge that set pending; returns how many edges later
  // step_done is seen (0 if it never arrives within the budget).
  task automatic wait_done(output int l, output int e);
    l = 0; e = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clock);
      if (target_eaten) e++;
      if (step_done) begin l = k; break; end
    end
  endtask

  // Two frame pulses make one tick with TICK_DIV=2.
  task automatic run_step(output int l, output int e);
    frame_pulse();
    frame_pulse();
    wait_done(l, e);
  endtask

  task automatic eat_at(input int x, input int y, output int l, output int e);
    target_x = COORD_W'(x); target_y = COORD_W'(y); target_valid = 1'b1;
    run_step(l, e);
    target_valid = 1'b0;
  endtask

  initial begin
    // ---- 1: reset values and plain step ----
    do_reset();
    chk("rst.head_x", 32'(head_x), 500);
    chk("rst.head_y", 32'(head_y), 400);
    chk_seg("rst.seg1", 1, 490, 400);
    chk_seg("rst.seg2", 2, 0, 0);
    chk("rst.length", 32'(length), 2);
    chk("rst.heading", 32'(heading), 0);
    chk("rst.move_ready", 32'(move_ready), 1);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.game_over", 32'(game_over), 0);
    chk("rst.step_done", 32'(step_done), 0);
    run_step(lat, eaten);
    // scan_n=1 -> step_done 5 edges after the edge that sets pending
    chk("s1.latency", 32'(lat), 5);
    chk("s1.head_x", 32'(head_x), 510);
    chk("s1.head_y", 32'(head_y), 400);
    chk_seg("s1.seg1", 1, 500, 400);
    chk("s1.length", 32'(length), 2);
    chk("s1.eaten", 32'(eaten), 0);

    // ---- 2: turns, latest command wins, command consumed ----
    do_reset();
    send_move(2'b10);
    run_step(lat, eaten);
    chk("t2a.heading", 32'(heading), 2);
    chk("t2a.head_x", 32'(head_x), 500);
    chk("t2a.head_y", 32'(head_y), 410);
    send_move(2'b10);
    send_move(2'b01);
    run_step(lat, eaten);
    chk("t2b.heading", 32'(heading), 0);
    chk("t2b.head_x", 32'(head_x), 510);
    chk("t2b.head_y", 32'(head_y), 410);
    run_step(lat, eaten);
    chk("t2c.heading", 32'(heading), 0);
    chk("t2c.head_x", 32'(head_x), 520);
    chk("t2c.move_ready", 32'(move_ready), 1);

    // ---- 3: eating, growth, saturation at MAX_LEN ----
    do_reset();
    eat_at(510, 400, lat, eaten);
    chk("t3.eaten", 32'(eaten), 1);
    chk("t3.latency", 32'(lat), 6);
    chk("t3.length", 32'(length), 3);
    chk_seg("t3.tail", 2, 490, 400);
    tot = 0;
    for (int i = 0; i < 22; i++) begin
      eat_at(520 + 10*i, 400, lat, eaten);
      tot += eaten;
    end
    chk("t3.grow_pulses", 32'(tot), 22);
    chk("t3.len_full", 32'(length), 25);
    eat_at(740, 400, lat, eaten);
    chk("t3.max.eaten", 32'(eaten), 1);
    chk("t3.max.length", 32'(length), 25);
    chk("t3.max.latency", 32'(lat), 29);
    chk("t3.max.head_x", 32'(head_x), 740);
    chk_seg("t3.max.seg24", 24, 500, 400);
    chk_seg("t3.max.seg25", 25, 0, 0);

    // ---- 4: wall hit ----
    do_reset();
    for (int i = 0; i < 49; i++) run_step(lat, eaten);
    chk("t4.head_x_edge", 32'(head_x), 990);
    chk("t4.no_over_yet", 32'(game_over), 0);
    run_step(lat, eaten);
    chk("t4.no_step_done", 32'(lat), 0);
    chk("t4.game_over", 32'(game_over), 1);
    chk("t4.head_x", 32'(head_x), 990);
    chk_seg("t4.seg1", 1, 980, 400);
    chk("t4.length", 32'(length), 2);
    chk("t4.move_ready", 32'(move_ready), 0);
    chk("t4.busy", 32'(busy), 0);
    send_move(2'b01);
    run_step(lat, eaten);
    chk("t4.frozen_done", 32'(lat), 0);
    chk("t4.frozen_head", 32'(head_x), 990);
    chk("t4.frozen_heading", 32'(heading), 0);
    chk("t4.sticky", 32'(game_over), 1);

    // ---- 5: self collision at length 5, none at length 4 ----
    do_reset();
    eat_at(510, 400, lat, eaten);
    eat_at(520, 400, lat, eaten);
    eat_at(530, 400, lat, eaten);
    chk("t5.len5", 32'(length), 5);
    for (int i = 0; i < 3; i++) begin
      send_move(2'b10);
      run_step(lat, eaten);
    end
    chk("t5.hit_over", 32'(game_over), 1);
    chk("t5.hit_head_x", 32'(head_x), 520);
    chk("t5.hit_head_y", 32'(head_y), 410);
    chk("t5.hit_length", 32'(length), 5);

    do_reset();
    eat_at(510, 400, lat, eaten);
    eat_at(520, 400, lat, eaten);
    chk("t5b.len4", 32'(length), 4);
    for (int i = 0; i < 3; i++) begin
      send_move(2'b10);
      run_step(lat, eaten);
    end
    chk("t5b.latency", 32'(lat), 7);
    chk("t5b.no_over", 32'(game_over), 0);
    chk("t5b.head_x", 32'(head_x), 510);
    chk("t5b.head_y", 32'(head_y), 400);
    chk("t5b.length", 32'(length), 4);

    // ---- 6: reset during SCAN, frame counted while busy ----
    do_reset();
    eat_at(510, 400, lat, eaten);
    eat_at(520, 400, lat, eaten);
    eat_at(530, 400, lat, eaten);
    frame_pulse();
    frame_pulse();
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (busy) begin lat = k; break; end
    end
    chk("t6.busy_seen", 32'(lat), 1);
    @(negedge clock);
    @(negedge clock);
    chk("t6.in_scan_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t6.rst.head_x", 32'(head_x), 500);
    chk("t6.rst.head_y", 32'(head_y), 400);
    chk("t6.rst.length", 32'(length), 2);
    chk_seg("t6.rst.seg1", 1, 490, 400);
    chk_seg("t6.rst.seg2", 2, 0, 0);
    chk("t6.rst.busy", 32'(busy), 0);
    chk("t6.rst.move_ready", 32'(move_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    frame_pulse();
    frame_pulse();
    @(negedge clock);
    frame_pulse();            // arrives while the step is running
    wait_done(lat, eaten);
    chk("t6.step1_done", 32'(lat != 0), 1);
    frame_pulse();            // completes the next tick
    wait_done(lat, eaten);
    chk("t6.step2_latency", 32'(lat), 5);
    chk("t6.head_x", 32'(head_x), 520);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
